// File: rtl/axi_w_order_router_if.sv
// W-channel routing bundle: arbitrated AW handshake, per-master W ports and slave-side W port.
// The router connects through the slave modport and the surrounding fabric through the master modport.
interface axi_w_order_router_if #(
  parameter int N_MASTER   = 5,
  parameter int LOG_MASTER = 3,
  parameter int W_WIDTH    = 73
);
  logic                               aw_valid_i;
  logic                               aw_ready_i;
  logic [LOG_MASTER-1:0]              aw_master_i;
  logic                               aw_full_o;
  logic [N_MASTER-1:0]                w_valid_i;
  logic [N_MASTER-1:0][W_WIDTH-1:0]   w_data_i;
  logic [N_MASTER-1:0]                w_last_i;
  logic [N_MASTER-1:0]                w_ready_o;
  logic                               w_valid_o;
  logic [W_WIDTH-1:0]                 w_data_o;
  logic                               w_last_o;
  logic                               w_ready_i;

  modport slave (
    input  aw_valid_i, aw_ready_i, aw_master_i,
    input  w_valid_i, w_data_i, w_last_i, w_ready_i,
    output aw_full_o, w_ready_o, w_valid_o, w_data_o, w_last_o
  );

  modport master (
    output aw_valid_i, aw_ready_i, aw_master_i,
    output w_valid_i, w_data_i, w_last_i, w_ready_i,
    input  aw_full_o, w_ready_o, w_valid_o, w_data_o, w_last_o
  );
endinterface

// File: rtl/axi_w_order_router.sv
// Records the winning master of each accepted AW in order and steers that master's
// W burst onto the slave W channel until WLAST, keeping W order aligned with AW order.
module axi_w_order_router #(
  parameter int N_MASTER   = 5,
  parameter int LOG_MASTER = 3,
  parameter int W_WIDTH    = 73,
  parameter int DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  axi_w_order_router_if.slave           bus,
  output logic [$clog2(DEPTH+1)-1:0]    count_o,
  output logic                          err_o
);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0]    PTR_LAST = PTR_W'(DEPTH-1);
  localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(DEPTH);
  localparam logic [LOG_MASTER:0] N_M      = (LOG_MASTER+1)'(N_MASTER);

  logic [LOG_MASTER-1:0] fifo_q [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  err_q, err_d;
  logic [LOG_MASTER-1:0] head;
  logic                  not_empty, full, push, idx_ok, push_ok, pop;

  assign not_empty = (count_q != '0);
  assign full      = (count_q == CNT_FULL);
  assign head      = fifo_q[rd_ptr_q];
  assign push      = bus.aw_valid_i & bus.aw_ready_i;
  assign idx_ok    = ({1'b0, bus.aw_master_i} < N_M);
  // A push at full is still accepted when the head burst retires in the same cycle.
  assign push_ok   = push & idx_ok & (~full | pop);
  assign pop       = bus.w_valid_o & bus.w_ready_i & bus.w_last_o;

  assign bus.aw_full_o = full;
  assign count_o       = count_q;
  assign err_o         = err_q;

  always_comb begin
    bus.w_valid_o = 1'b0;
    bus.w_data_o  = '0;
    bus.w_last_o  = 1'b0;
    bus.w_ready_o = '0;
    if (not_empty) begin
      bus.w_valid_o       = bus.w_valid_i[head];
      bus.w_data_o        = bus.w_data_i[head];
      bus.w_last_o        = bus.w_last_i[head];
      bus.w_ready_o[head] = bus.w_ready_i;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    err_d    = err_q | (push & ~push_ok);
    if (push_ok) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Entry storage needs no reset: it is only observed while count_q is non-zero.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr_q] <= bus.aw_master_i;
  end
endmodule

// File: tb/tb_axi_w_order_router.sv
// Directed bench for axi_w_order_router: ordering, stalls, full/error handling,
// empty hold-off, pointer wrap and mid-burst reset, with hand-computed expectations.
module tb_axi_w_order_router;
  localparam int N  = 5;
  localparam int LM = 3;
  localparam int WW = 73;
  localparam int D  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] count;
  logic       err;
  int         n_assert = 0;
  int         n_fail   = 0;

  axi_w_order_router_if #(.N_MASTER(N), .LOG_MASTER(LM), .W_WIDTH(WW)) bus ();

  axi_w_order_router #(.N_MASTER(N), .LOG_MASTER(LM), .W_WIDTH(WW), .DEPTH(D)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .count_o (count),
    .err_o   (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] m);
    bus.aw_valid_i  = 1'b1;
    bus.aw_ready_i  = 1'b1;
    bus.aw_master_i = m;
  endtask

  task automatic nopush();
    bus.aw_valid_i = 1'b0;
    bus.aw_ready_i = 1'b0;
  endtask

  task automatic beat(input int m, input logic v, input logic [WW-1:0] d, input logic l);
    bus.w_valid_i[m] = v;
    bus.w_data_i[m]  = d;
    bus.w_last_i[m]  = l;
  endtask

  task automatic clr_w();
    bus.w_valid_i = '0;
    bus.w_data_i  = '0;
    bus.w_last_i  = '0;
  endtask

  initial begin
    int dat5 [5];
    logic [4:0] rdy5;
    dat5 = '{'h40, 'h41, 'h41, 'h42, 'h42};
    rdy5 = 5'b10101;

    rst_n = 1'b0;
    nopush();
    bus.aw_master_i = '0;
    clr_w();
    bus.w_ready_i = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    settle();
    check("rst_count", count, 0);
    check("rst_err", err, 0);
    check("rst_full", bus.aw_full_o, 0);
    check("rst_wvalid", bus.w_valid_o, 0);
    check("rst_wready", bus.w_ready_o, 0);
    check("rst_wlast", bus.w_last_o, 0);
    check("rst_wdata", bus.w_data_o, 0);

    // single 4-beat burst from master 2
    push(3'd2);
    beat(2, 1'b1, 73'h1_0000_0000_0000_00A0, 1'b0);
    bus.w_ready_i = 1'b1;
    settle();
    check("t1_nofall_valid", bus.w_valid_o, 0);
    check("t1_nofall_ready", bus.w_ready_o, 0);
    tick();
    nopush();
    settle();
    check("t1_count1", count, 1);
    check("t1_valid", bus.w_valid_o, 1);
    for (int b = 0; b < 4; b++) begin
      beat(2, 1'b1, 73'h1_0000_0000_0000_00A0 + 73'(b), (b == 3));
      settle();
      check("t1_data", bus.w_data_o, 73'h1_0000_0000_0000_00A0 + 73'(b));
      check("t1_ready", bus.w_ready_o, 5'b00100);
      check("t1_last", bus.w_last_o, (b == 3));
      check("t1_count", count, 1);
      tick();
    end
    beat(2, 1'b0, '0, 1'b0);
    settle();
    check("t1_count0", count, 0);
    check("t1_idle", bus.w_valid_o, 0);

    // interleaved order 1,3,1 with two-beat bursts
    push(3'd1);
    beat(1, 1'b1, 73'h10, 1'b0);
    beat(3, 1'b1, 73'h30, 1'b0);
    tick();
    push(3'd3);
    settle();
    check("t2_b_data", bus.w_data_o, 73'h10);
    check("t2_b_ready", bus.w_ready_o, 5'b00010);
    tick();
    beat(1, 1'b1, 73'h11, 1'b1);
    push(3'd1);
    settle();
    check("t2_c_data", bus.w_data_o, 73'h11);
    check("t2_c_last", bus.w_last_o, 1);
    check("t2_c_ready", bus.w_ready_o, 5'b00010);
    tick();
    beat(1, 1'b1, 73'h12, 1'b0);
    nopush();
    settle();
    check("t2_d_data", bus.w_data_o, 73'h30);
    check("t2_d_ready", bus.w_ready_o, 5'b01000);
    check("t2_d_count", count, 2);
    tick();
    beat(3, 1'b1, 73'h31, 1'b1);
    settle();
    check("t2_e_data", bus.w_data_o, 73'h31);
    check("t2_e_last", bus.w_last_o, 1);
    tick();
    beat(3, 1'b0, '0, 1'b0);
    settle();
    check("t2_f_data", bus.w_data_o, 73'h12);
    check("t2_f_ready", bus.w_ready_o, 5'b00010);
    check("t2_f_count", count, 1);
    tick();
    beat(1, 1'b1, 73'h13, 1'b1);
    settle();
    check("t2_g_data", bus.w_data_o, 73'h13);
    check("t2_g_valid", bus.w_valid_o, 1);
    tick();
    beat(1, 1'b0, '0, 1'b0);
    settle();
    check("t2_count0", count, 0);

    // fill, push+pop at full, overflow drop, drain
    for (int m = 0; m < 4; m++) begin
      push(3'(m));
      tick();
    end
    nopush();
    settle();
    check("t3_count4", count, 4);
    check("t3_full", bus.aw_full_o, 1);
    check("t3_err0", err, 0);
    check("t3_head_idle", bus.w_valid_o, 0);
    push(3'd4);
    beat(0, 1'b1, 73'h55, 1'b1);
    settle();
    check("t3_pp_valid", bus.w_valid_o, 1);
    check("t3_pp_ready", bus.w_ready_o, 5'b00001);
    tick();
    beat(0, 1'b0, '0, 1'b0);
    nopush();
    settle();
    check("t3_pp_count", count, 4);
    check("t3_pp_err", err, 0);
    check("t3_pp_full", bus.aw_full_o, 1);
    push(3'd0);
    tick();
    nopush();
    settle();
    check("t3_ovf_err", err, 1);
    check("t3_ovf_count", count, 4);
    for (int m = 1; m <= 4; m++) beat(m, 1'b1, 73'h60 + 73'(m), 1'b1);
    for (int k = 0; k < 4; k++) begin
      settle();
      check("t3_drain_data", bus.w_data_o, 73'h60 + 73'(k + 1));
      check("t3_drain_ready", bus.w_ready_o, 128'(1) << (k + 1));
      tick();
    end
    clr_w();
    settle();
    check("t3_count0", count, 0);
    check("t3_notfull", bus.aw_full_o, 0);

    // W before AW is held off
    beat(0, 1'b1, 73'h1234, 1'b0);
    bus.w_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("t4_hold_valid", bus.w_valid_o, 0);
      check("t4_hold_ready", bus.w_ready_o, 0);
      check("t4_hold_data", bus.w_data_o, 0);
      tick();
    end
    push(3'd0);
    settle();
    check("t4_push_valid", bus.w_valid_o, 0);
    tick();
    nopush();
    beat(0, 1'b1, 73'h1234, 1'b1);
    settle();
    check("t4_fwd_valid", bus.w_valid_o, 1);
    check("t4_fwd_data", bus.w_data_o, 73'h1234);
    check("t4_fwd_ready", bus.w_ready_o, 5'b00001);
    tick();
    beat(0, 1'b0, '0, 1'b0);
    settle();
    check("t4_count0", count, 0);

    // slave backpressure during a 3-beat burst from master 4
    push(3'd4);
    tick();
    nopush();
    for (int i = 0; i < 5; i++) begin
      bus.w_ready_i = rdy5[i];
      beat(4, 1'b1, 73'(dat5[i]), (i >= 3));
      settle();
      check("t5_data", bus.w_data_o, 73'(dat5[i]));
      check("t5_last", bus.w_last_o, (i >= 3));
      check("t5_ready", bus.w_ready_o, rdy5[i] ? 5'b10000 : 5'b00000);
      check("t5_count", count, 1);
      tick();
    end
    bus.w_ready_i = 1'b1;
    beat(4, 1'b0, '0, 1'b0);
    settle();
    check("t5_count0", count, 0);

    // pointer wrap with steady push/pop, then error and mid-burst reset
    for (int m = 0; m < 5; m++) beat(m, 1'b1, 73'h70 + 73'(m), 1'b1);
    for (int i = 0; i < 10; i++) begin
      push(3'(i % 5));
      settle();
      if (i > 0) begin
        check("t6_wrap_data", bus.w_data_o, 73'h70 + 73'((i - 1) % 5));
        check("t6_wrap_ready", bus.w_ready_o, 128'(1) << ((i - 1) % 5));
      end
      tick();
    end
    nopush();
    clr_w();
    beat(4, 1'b1, 73'h80, 1'b0);
    settle();
    check("t6_count1", count, 1);
    check("t6_head4", bus.w_data_o, 73'h80);
    push(3'd6);
    tick();
    nopush();
    beat(4, 1'b1, 73'h81, 1'b0);
    settle();
    check("t6_badidx_err", err, 1);
    check("t6_badidx_count", count, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    settle();
    check("t6_rst_count", count, 0);
    check("t6_rst_err", err, 0);
    check("t6_rst_valid", bus.w_valid_o, 0);
    check("t6_rst_ready", bus.w_ready_o, 0);
    push(3'd3);
    beat(3, 1'b1, 73'h93, 1'b1);
    tick();
    nopush();
    settle();
    check("t6_post_data", bus.w_data_o, 73'h93);
    check("t6_post_ready", bus.w_ready_o, 5'b01000);
    tick();
    clr_w();
    settle();
    check("t6_post_count", count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
